// File: rtl/simple_stim_driver.sv
// simple_stim_driver
//   Transmit side for the `simple` benchmark core. A stimulus word of VECS
//   2-bit vectors is accepted over a valid/ready handshake. Its vectors are
//   then driven one per clock onto the core's inp1/inp2 inputs. The core's
//   `out` is sampled LAT cycles after each vector, and the captured bits are
//   returned as one response word over a second valid/ready handshake.
//
// Ports
//   iccad_clk    clock, rising edge
//   iccad_rst_n  asynchronous active-low reset
//   in_valid     stimulus word valid
//   in_ready     high while IDLE (combinational from state)
//   in_data      vector k = {in_data[2k+1] (inp2), in_data[2k] (inp1)}
//   inp1, inp2   registered drives to the core inputs
//   out_obs      core `out`, sampled on clock edges
//   rsp_valid    response word valid
//   rsp_ready    consumer accepts the response
//   rsp_data     bit k = out_obs sampled for vector k
//   busy         high whenever the state is not IDLE
module simple_stim_driver #(
  parameter int VECS = 8,
  parameter int LAT  = 2,
  parameter int CW   = 5
) (
  input  logic              iccad_clk,
  input  logic              iccad_rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*VECS-1:0] in_data,
  output logic              inp1,
  output logic              inp2,
  input  logic              out_obs,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [VECS-1:0]   rsp_data,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*VECS-1:0] data_q, data_d;
  logic              inp1_q, inp1_d;
  logic              inp2_q, inp2_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [VECS-1:0]   rsp_data_q, rsp_data_d;

  // cnt_nxt is the step being entered on this edge. Vector cnt_nxt is
  // driven, and response bit (cnt_nxt - LAT) is captured.
  logic [CW-1:0]   cnt_nxt;
  logic [VECS-1:0] vec_hit;   // one-hot: vector gi is driven on this edge
  logic [VECS-1:0] cap_hit;   // one-hot: response bit gi is captured on this edge
  logic [VECS-1:0] vec_inp1;
  logic [VECS-1:0] vec_inp2;
  logic            last_cap;

  assign cnt_nxt  = cnt_q + CW'(1);
  assign last_cap = (cnt_nxt == CW'(VECS - 1 + LAT));

  genvar gi;
  generate
    for (gi = 0; gi < VECS; gi++) begin : g_vec
      assign vec_hit[gi]  = (cnt_nxt == CW'(gi));
      assign cap_hit[gi]  = (cnt_nxt == CW'(gi + LAT));
      assign vec_inp1[gi] = data_q[2*gi];
      assign vec_inp2[gi] = data_q[2*gi+1];
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    inp1_d      = inp1_q;
    inp2_d      = inp2_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;

    case (state_q)
      ST_IDLE: begin
        inp1_d = 1'b0;
        inp2_d = 1'b0;
        if (in_valid) begin
          data_d     = in_data;
          inp1_d     = in_data[0];
          inp2_d     = in_data[1];
          cnt_d      = '0;
          rsp_data_d = '0;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        cnt_d      = cnt_nxt;
        // Once every vector has been sent, vec_hit is all-zero and the
        // core inputs fall to 0 while the tail of the latency drains.
        inp1_d     = |(vec_hit & vec_inp1);
        inp2_d     = |(vec_hit & vec_inp2);
        rsp_data_d = (rsp_data_q & ~cap_hit) | (cap_hit & {VECS{out_obs}});
        if (last_cap) begin
          rsp_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        inp1_d = 1'b0;
        inp2_d = 1'b0;
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        // Unused encoding: fall back to a quiet IDLE.
        state_d     = ST_IDLE;
        cnt_d       = '0;
        inp1_d      = 1'b0;
        inp2_d      = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iccad_clk or negedge iccad_rst_n) begin
    if (!iccad_rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      data_q      <= '0;
      inp1_q      <= 1'b0;
      inp2_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      inp1_q      <= inp1_d;
      inp2_q      <= inp2_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign inp1      = inp1_q;
  assign inp2      = inp2_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_simple_stim_driver.sv
// Directed bench for simple_stim_driver (VECS=8, LAT=2). The loopback
// model feeds inp1 through one bench flop into out_obs. Together with the
// DUT's own inp1 register, this makes two flops between the vector and
// out_obs, so response bit k equals inp1 of vector k.
module tb_simple_stim_driver;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        inp1;
  logic        inp2;
  logic        out_obs;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic        busy;

  logic        loop_en;
  logic        rnd_obs;
  logic        lb_q;
  int          n_cmp;
  int          n_bad;
  int          cyc;

  simple_stim_driver #(.VECS(8), .LAT(2), .CW(5)) dut (
    .iccad_clk   (clk),
    .iccad_rst_n (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .inp1        (inp1),
    .inp2        (inp2),
    .out_obs     (out_obs),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) lb_q <= 1'b0;
    else        lb_q <= inp1;
  end

  assign out_obs = loop_en ? lb_q : rnd_obs;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Entered at the negedge just after acceptance edge e0. Checks every
  // vector, the response timing, then holds rsp_ready low for 'hold' cycles
  // (optionally presenting next_w), and completes the response handshake.
  task automatic observe_word(input logic [15:0] w, input logic [7:0] exp_rsp,
                              input int hold, input logic present_next,
                              input logic [15:0] next_w);
    logic [7:0] zero8;
    zero8 = 8'h00;
    check_eq("busy_e0", busy, 1'b1);
    check_eq("rsp_clr_e0", rsp_data, zero8);
    for (int k = 0; k < 8; k++) begin
      check_eq($sformatf("vec%0d", k), {inp2, inp1}, {w[2*k+1], w[2*k]});
      check_eq($sformatf("rv_lo%0d", k), rsp_valid, 1'b0);
      step();
    end
    check_eq("vec_tail", {inp2, inp1}, 2'b00);
    check_eq("rv_e8", rsp_valid, 1'b0);
    step();
    check_eq("rv_e9", rsp_valid, 1'b1);
    check_eq("rsp_data", rsp_data, exp_rsp);
    check_eq("inready_done", in_ready, 1'b0);
    check_eq("vec_done", {inp2, inp1}, 2'b00);
    for (int h = 0; h < hold; h++) begin
      if (present_next) begin
        in_valid = 1'b1;
        in_data  = next_w;
      end
      step();
      check_eq("hold_rv", rsp_valid, 1'b1);
      check_eq("hold_data", rsp_data, exp_rsp);
      check_eq("hold_inready", in_ready, 1'b0);
      check_eq("hold_busy", busy, 1'b1);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check_eq("rv_after_hs", rsp_valid, 1'b0);
    check_eq("inready_after_hs", in_ready, 1'b1);
    $display("word %04h -> rsp %02h (expect %02h)", w, rsp_data, exp_rsp);
  endtask

  task automatic send_word(input logic [15:0] w);
    in_valid = 1'b1;
    in_data  = w;
    check_eq("inready_accept", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] words [3];
    logic [7:0]  exps  [3];
    int sent, rcv, last_cyc, budget;

    n_cmp = 0; n_bad = 0; cyc = 0;
    rst_n = 1'b0; in_valid = 1'b1; in_data = 16'hFFFF;
    rsp_ready = 1'b0; loop_en = 1'b0; rnd_obs = 1'b0;

    // Reset with in_valid high and random out_obs.
    for (int i = 0; i < 4; i++) begin
      rnd_obs = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    check_eq("rst_inp", {inp2, inp1}, 2'b00);
    check_eq("rst_rv", rsp_valid, 1'b0);
    check_eq("rst_rd", rsp_data, 8'h00);
    check_eq("rst_busy", busy, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    loop_en = 1'b1;
    step();
    check_eq("rst_inready", in_ready, 1'b1);
    check_eq("rst_idle_busy", busy, 1'b0);
    $display("reset released");

    // Loopback words.
    send_word(16'h5555); observe_word(16'h5555, 8'hFF, 0, 1'b0, 16'h0);
    send_word(16'h0001); observe_word(16'h0001, 8'h01, 0, 1'b0, 16'h0);
    send_word(16'h4000); observe_word(16'h4000, 8'h80, 0, 1'b0, 16'h0);

    // Backpressure. The held word 16'h4000 must not be consumed until after the handshake.
    send_word(16'h5555); observe_word(16'h5555, 8'hFF, 5, 1'b1, 16'h4000);
    check_eq("bp_pending_valid", in_valid, 1'b1);
    step();
    in_valid = 1'b0;
    observe_word(16'h4000, 8'h80, 0, 1'b0, 16'h0);

    // Reset between e0+3 and e0+4.
    send_word(16'h5555);
    step(); step(); step();
    check_eq("mid_inp1_pre", inp1, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_async_inp1", inp1, 1'b0);
    check_eq("mid_async_busy", busy, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      step();
      check_eq("mid_no_rv", rsp_valid, 1'b0);
    end
    rst_n = 1'b1;
    step();
    $display("reset mid-run done");
    send_word(16'hAAAA); observe_word(16'hAAAA, 8'h00, 0, 1'b0, 16'h0);

    // Back-to-back with in_valid and rsp_ready held high.
    words[0] = 16'h5555; exps[0] = 8'hFF;
    words[1] = 16'h0001; exps[1] = 8'h01;
    words[2] = 16'h4000; exps[2] = 8'h80;
    sent = 0; rcv = 0; last_cyc = 0; budget = 0;
    rsp_ready = 1'b1;
    while (rcv < 3 && budget < 100) begin
      if (rsp_valid) begin
        check_eq($sformatf("b2b_rsp%0d", rcv), rsp_data, exps[rcv]);
        if (rcv > 0) check_eq($sformatf("b2b_gap%0d", rcv), cyc - last_cyc, 11);
        $display("b2b response %0d: %02h at cycle %0d", rcv, rsp_data, cyc);
        last_cyc = cyc;
        rcv++;
      end
      if (sent < 3) begin
        in_valid = 1'b1;
        in_data  = words[sent];
        if (in_ready) sent++;
      end else begin
        in_valid = 1'b0;
      end
      step();
      budget++;
    end
    check_eq("b2b_count", rcv, 3);
    rsp_ready = 1'b0;
    in_valid  = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/simple_stim_driver.md
Name: simple_stim_driver

Overview:
- Transmit side for the `simple` benchmark core.
- Takes parallel stimulus words over a valid/ready handshake and drives them one 2-bit vector per clock onto the core's `inp1`/`inp2` inputs.
- Samples the core's `out` a fixed number of cycles after each vector and returns the captured bits as a response word over a second valid/ready handshake.
- Sits between the test/CTS harness and the `simple` netlist, in the `iccad_clk` domain.

Parameters:
- VECS, 8, number of 2-bit vectors per stimulus word (>=1).
- LAT, 2, cycles from a vector being driven to its effect being sampled on `out_obs` (>=1).
- CW, 5, counter width; must hold VECS+LAT-1.

Ports:
- iccad_clk  input  1  clock, rising edge.
- iccad_rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  stimulus word valid.
- in_ready  output  1  block can accept a stimulus word.
- in_data  input  2*VECS  vector k = {in_data[2k+1] (inp2), in_data[2k] (inp1)}.
- inp1  output  1  drives core `inp1`; registered.
- inp2  output  1  drives core `inp2`; registered.
- out_obs  input  1  core `out`; sampled on clock edges.
- rsp_valid  output  1  response word valid.
- rsp_ready  input  1  consumer accepts response.
- rsp_data  output  VECS  bit k = `out_obs` sampled for vector k.
- busy  output  1  high when state is not IDLE.

Behaviour:
- Reset: iccad_rst_n low sets everything immediately, without waiting for a clock edge.
  - state=IDLE, cnt=0.
  - inp1=inp2=0, rsp_valid=0, rsp_data=0.
  - Any in-flight word or response is discarded.
- in_ready = (state==IDLE), combinational from state. busy = (state!=IDLE).
- States:
  - IDLE: on the edge with in_valid&&in_ready (edge e0):
    - Latch in_data.
    - Drive vector 0: inp1<=in_data[0], inp2<=in_data[1].
    - cnt<=0; go to RUN.
  - RUN: each edge with cnt=c:
    - cnt<=c+1.
    - If c+1<VECS, drive vector c+1; otherwise drive inp1=inp2=0.
    - If c+1>=LAT, set rsp_data[c+1-LAT] <= out_obs.
    - When c+1-LAT==VECS-1, also set rsp_valid<=1 and go to DONE.
  - DONE: rsp_valid=1; rsp_data and inputs held stable; inp1=inp2=0.
    - On an edge with rsp_ready=1: rsp_valid<=0, go to IDLE.
- Timing:
  - Vector k is visible after edge e0+k.
  - Response bit k is the value of out_obs sampled at edge e0+k+LAT.
  - rsp_valid rises after edge e0+VECS-1+LAT, i.e. VECS+LAT-1 cycles after acceptance.
- Handshake rules:
  - in_valid seen while not IDLE is ignored; the word is not consumed.
  - No same-cycle bypass: in_ready rises the cycle after the response handshake.
  - Minimum word-to-word spacing is VECS+LAT+1 cycles with rsp_ready tied high.
- Bit gaps:
  - rsp_data bits not yet captured read 0.
  - rsp_data is cleared on acceptance at e0.
- Reset mid-RUN or mid-DONE: everything returns to reset values. The next accepted word behaves exactly as from a fresh reset.
- No state besides IDLE/RUN/DONE is reachable. An illegal encoding recovers to IDLE.

Test Plan:
- Reset: hold iccad_rst_n=0 with in_valid=1 and random out_obs -> inp1=inp2=0, rsp_valid=0, rsp_data=0, busy=0; in_ready=1 after release.
- Loopback, with out_obs = inp1 delayed by two flops (LAT=2): in_data=16'h5555 -> inp1=1, inp2=0 for edges e0..e0+7, then 0; rsp_valid rises after e0+9; rsp_data=8'hFF.
- Same loopback, in_data=16'h0001 -> inp1 high only for the cycle after e0; rsp_data=8'h01. Then in_data=16'h4000 -> rsp_data=8'h80.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid rises -> rsp_data stable, in_ready=0, a new in_valid is not consumed. With rsp_ready=1 the response handshakes and in_ready=1 the following cycle; the held word is then accepted.
- Reset mid-RUN: assert iccad_rst_n=0 between e0+3 and e0+4 -> outputs clear asynchronously, no rsp_valid. After release, a fresh word 16'hAAAA under loopback -> rsp_data=8'h00, with inp2=1 for all 8 vectors.
- Back-to-back: in_valid and rsp_ready held high for 3 words -> exactly 3 responses in order, spaced 11 cycles apart (VECS+LAT+1).
